pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Pipeline control unit for the 5-stage MIPS32 core. It merges stall requests from the ID stage (load-use hazards) and the EX stage (multi-cycle ops) into the per-stage stall vector used by pc_reg and the if_id, id_ex, ex_mem and mem_wb latches. An internal FSM and down-counter sequence EX multi-cycle operations (mult/div style) for a programmed number of cycles. It also handles a synchronous flush that aborts a sequence in progress.

Parameters:
CNT_W, 6, width of the multi-cycle length field and the internal counter.
WDOG_LIMIT, 64, consecutive stall cycles before the watchdog trips. Used only with STALL_WATCHDOG_EN.

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high (`RstEnable = 1'b1)
stallreq_id_i  input  1  stall request from id (load-use)
stallreq_ex_i  input  1  stall request from ex (generic)
mc_start_i  input  1  one-cycle pulse from ex: start a multi-cycle op
mc_cycles_i  input  CNT_W  length N of the op in cycles; sampled only with mc_start_i
flush_i  input  1  abort the current sequence (exception/branch-flush)
stall_o  output  6  stall vector: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
busy_o  output  1  FSM in RUN
mc_done_o  output  1  one-cycle pulse: multi-cycle result valid in ex
wdog_o  output  1  watchdog tripped (sticky)

Behaviour:
- Reset: while rst=1, the FSM goes to IDLE and cnt goes to 0. stall_o=6'b000000, busy_o=0, mc_done_o=0 and wdog_o=0; these values are forced combinationally during reset as well.
- FSM states and transitions:
  - IDLE: on mc_start_i, let Neff = max(mc_cycles_i,1) and load cnt = Neff-1. If cnt=0 the next state is DONE, otherwise RUN. With no start, stay in IDLE.
  - RUN: decrement cnt each cycle. If cnt==1, the next state is DONE. mc_start_i is ignored in RUN.
  - DONE: lasts 1 cycle. mc_done_o=1 for this cycle. The next state is IDLE, unless mc_start_i=1 in the same cycle; then it is handled exactly as in IDLE (back-to-back ops).
- Stall vector (combinational):
  - ex_hold = stallreq_ex_i OR (state==RUN) OR (mc_start_i accepted this cycle in IDLE or DONE).
  - If ex_hold=1, stall_o=6'b001111.
  - Else if stallreq_id_i=1, stall_o=6'b000111.
  - Else stall_o=6'b000000.
- Multi-cycle latency: stall_o[3] is high for exactly Neff consecutive cycles, counting from the start cycle. mc_done_o pulses in the first cycle after the last stall cycle, and stall_o[3]=0 in that cycle unless a new op starts or stallreq_ex_i is high.
- busy_o = (state==RUN), registered-state decode.
- Priority: rst > flush_i > FSM sequencing.
- Flush: flush_i=1 forces stall_o=0 in that cycle. On the next edge the FSM goes to IDLE and cnt to 0, and no mc_done_o is produced for the aborted op. A mc_start_i in the flush cycle is dropped.
- Simultaneous ID and EX requests: EX wins and stall_o=6'b001111. The ID hazard resolves naturally once EX releases.
- Counter: unsigned CNT_W bits and never wraps. mc_cycles_i=0 is treated as 1. The maximum length is 2^CNT_W-1.

Optional Feature:
STALL_WATCHDOG_EN:
- Defined:
  - A CNT_W+2-bit counter increments each cycle stall_o!=0 and clears when stall_o==0 or on flush.
  - When it reaches WDOG_LIMIT, wdog_o is set and held until rst. On the following edge the FSM is forced to IDLE, and stall_o is forced to 0 from that cycle on, for as long as wdog_o=1.
- Not defined: wdog_o is tied to 0 and no watchdog logic is built.

Test Plan:
- Reset: hold rst=1 for 3 cycles with stallreq_id_i=1 and mc_start_i=1 -> stall_o=0, busy_o=0 and mc_done_o=0 throughout; FSM in IDLE after release.
- Load-use: stallreq_id_i=1 for 1 cycle -> stall_o=6'b000111 for that cycle only, then 0.
- Multi-cycle: mc_start_i with mc_cycles_i=4 at cycle T -> stall_o=6'b001111 in T..T+3, busy_o=1 in T+1..T+3, mc_done_o=1 at T+4 with stall_o=0.
- Edge lengths: mc_cycles_i=0 and mc_cycles_i=1 -> 1 stall cycle, then mc_done_o on the next cycle, busy_o never 1. A second mc_start_i (N=2) in the DONE cycle -> stall continues for 2 more cycles, then a second mc_done_o.
- Flush mid-op: start with N=10 and assert flush_i at T+3 -> stall_o=0 at T+3, FSM in IDLE at T+4, no mc_done_o ever.
- Watchdog (macro on, WDOG_LIMIT=8): hold stallreq_ex_i=1 -> wdog_o=1 after the 8th consecutive stall cycle, stall_o=0 from then on; wdog_o clears only on rst.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Pipeline stall controller for the 5-stage MIPS32 core. It merges the ID-stage
// load-use request and the EX-stage requests into one per-stage stall vector.
// It also sequences multi-cycle EX operations (mult/div style) with a small FSM
// and a down-counter, and it aborts a running sequence on a synchronous flush.
//
// Optional feature: define STALL_WATCHDOG_EN to build a consecutive-stall
// watchdog. When the macro is not defined, wdog_o is tied low and no watchdog
// logic is built.
//
// Parameters
//   CNT_W       width of the multi-cycle length field and the internal counter
//   WDOG_LIMIT  consecutive stall cycles before the watchdog trips
//               (only used when STALL_WATCHDOG_EN is defined)
//
// Ports
//   clk            core clock, all state updates on the rising edge
//   rst            synchronous reset, active-high
//   stallreq_id_i  load-use stall request from ID
//   stallreq_ex_i  generic stall request from EX
//   mc_start_i     one-cycle pulse from EX that starts a multi-cycle op
//   mc_cycles_i    length N of the op, sampled only together with mc_start_i
//   flush_i        aborts the current sequence (exception / branch flush)
//   stall_o        stall vector: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
//   busy_o         FSM is in RUN
//   mc_done_o      one-cycle pulse: the multi-cycle result is valid in EX
//   wdog_o         watchdog tripped (sticky until rst)
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
   parameter int CNT_W      = 6,
   parameter int WDOG_LIMIT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id_i,
   input  logic             stallreq_ex_i,
   input  logic             mc_start_i,
   input  logic [CNT_W-1:0] mc_cycles_i,
   input  logic             flush_i,
   output logic [5:0]       stall_o,
   output logic             busy_o,
   output logic             mc_done_o,
   output logic             wdog_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;  // freeze pc, if, id
   localparam logic [5:0] STALL_EX   = 6'b001111;  // freeze pc, if, id, ex

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W-1:0] neff_m1_s;
   logic             start_acc_s;
   logic             ex_hold_s;
   logic [5:0]       stall_s;
   logic             wdog_s;

   // Effective length minus one: a zero-length request runs as a one-cycle op.
   always_comb begin
      neff_m1_s = {CNT_W{1'b0}};
      if (mc_cycles_i == {CNT_W{1'b0}}) begin
         neff_m1_s = {CNT_W{1'b0}};
      end else begin
         neff_m1_s = mc_cycles_i - {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // A start is only taken in IDLE or DONE; flush and a tripped watchdog drop it.
   always_comb begin
      start_acc_s = 1'b0;
      if (mc_start_i && !flush_i && !wdog_s &&
          ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
         start_acc_s = 1'b1;
      end else begin
         start_acc_s = 1'b0;
      end
   end

   // Next-state and next-count logic of the multi-cycle sequencer.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (flush_i || wdog_s) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               // DONE accepts a new start exactly like IDLE (back-to-back ops).
               if (start_acc_s) begin
                  cnt_nxt_s = neff_m1_s;
                  if (neff_m1_s == {CNT_W{1'b0}}) begin
                     state_nxt_s = ST_DONE;
                  end else begin
                     state_nxt_s = ST_RUN;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = {CNT_W{1'b0}};
               end
            end
            ST_RUN: begin
               // "<= 1" rather than "== 1" so a corrupted zero count still exits.
               if (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  state_nxt_s = ST_DONE;
                  cnt_nxt_s   = {CNT_W{1'b0}};
               end else begin
                  state_nxt_s = ST_RUN;
                  cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Sequencer state and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // The start cycle itself already holds EX, so EX is frozen for exactly Neff cycles.
   always_comb begin
      ex_hold_s = 1'b0;
      if (stallreq_ex_i || (state_r == ST_RUN) || start_acc_s) begin
         ex_hold_s = 1'b1;
      end else begin
         ex_hold_s = 1'b0;
      end
   end

   // Stall vector: reset, flush and a tripped watchdog release everything; EX beats ID.
   always_comb begin
      stall_s = STALL_NONE;
      if (rst || flush_i || wdog_s) begin
         stall_s = STALL_NONE;
      end else if (ex_hold_s) begin
         stall_s = STALL_EX;
      end else if (stallreq_id_i) begin
         stall_s = STALL_ID;
      end else begin
         stall_s = STALL_NONE;
      end
   end

`ifdef STALL_WATCHDOG_EN
   localparam int             WD_W   = CNT_W + 2;
   localparam logic [WD_W-1:0] WD_LIM = WD_W'(WDOG_LIMIT);

   logic [WD_W-1:0] wd_cnt_r;
   logic [WD_W-1:0] wd_inc_s;
   logic            wdog_r;

   assign wd_inc_s = wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};

   // Consecutive-stall counter; trips the sticky flag on the edge that reaches the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_r <= {WD_W{1'b0}};
         wdog_r   <= 1'b0;
      end else if (flush_i || (stall_s == STALL_NONE)) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else begin
         if (wd_cnt_r != {WD_W{1'b1}}) begin
            wd_cnt_r <= wd_inc_s;
         end
         if (wd_inc_s == WD_LIM) begin
            wdog_r <= 1'b1;
         end
      end
   end

   assign wdog_s = wdog_r;
`else
   logic wdog_unused_s;

   assign wdog_s        = 1'b0;
   assign wdog_unused_s = ^WDOG_LIMIT;
`endif

   assign stall_o   = stall_s;
   assign busy_o    = !rst && (state_r == ST_RUN);
   assign mc_done_o = !rst && (state_r == ST_DONE);
   assign wdog_o    = !rst && wdog_s;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed-vector bench for pipe_stall_ctrl. Each vector drives one cycle of
// inputs and pushes the hand-computed outputs into a scoreboard queue; a
// monitor on the falling edge pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

   localparam int CNT_W = 6;
`ifdef STALL_WATCHDOG_EN
   localparam int WDL = 8;
`else
   localparam int WDL = 64;
`endif

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_ID   = 6'b000111;
   localparam logic [5:0] S_EX   = 6'b001111;

   logic             clk;
   logic             rst;
   logic             stallreq_id_i;
   logic             stallreq_ex_i;
   logic             mc_start_i;
   logic [CNT_W-1:0] mc_cycles_i;
   logic             flush_i;
   logic [5:0]       stall_o;
   logic             busy_o;
   logic             mc_done_o;
   logic             wdog_o;

   typedef struct {
      string      name;
      logic [5:0] stall;
      logic       busy;
      logic       done;
      logic       wdog;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_vec;
   int   n_err;

   pipe_stall_ctrl #(
      .CNT_W      (CNT_W),
      .WDOG_LIMIT (WDL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq_id_i (stallreq_id_i),
      .stallreq_ex_i (stallreq_ex_i),
      .mc_start_i    (mc_start_i),
      .mc_cycles_i   (mc_cycles_i),
      .flush_i       (flush_i),
      .stall_o       (stall_o),
      .busy_o        (busy_o),
      .mc_done_o     (mc_done_o),
      .wdog_o        (wdog_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: pops one expectation per cycle, mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         n_vec = n_vec + 1;
         if ({stall_o, busy_o, mc_done_o, wdog_o} !==
             {mon_e.stall, mon_e.busy, mon_e.done, mon_e.wdog}) begin
            n_err = n_err + 1;
            $display("FAIL %s: got stall=%b busy=%b done=%b wdog=%b, expected stall=%b busy=%b done=%b wdog=%b",
                     mon_e.name, stall_o, busy_o, mc_done_o, wdog_o,
                     mon_e.stall, mon_e.busy, mon_e.done, mon_e.wdog);
         end
      end
   end

   // One cycle of stimulus plus its expected outputs.
   task automatic apply(input string name, input logic r, input logic id, input logic ex,
                        input logic st, input logic [CNT_W-1:0] cyc, input logic fl,
                        input logic [5:0] es, input logic eb, input logic ed, input logic ew);
      exp_t e;
      e.name  = name;
      e.stall = es;
      e.busy  = eb;
      e.done  = ed;
      e.wdog  = ew;
      sb_q.push_back(e);
      rst           = r;
      stallreq_id_i = id;
      stallreq_ex_i = ex;
      mc_start_i    = st;
      mc_cycles_i   = cyc;
      flush_i       = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         apply(name, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      rst           = 1'b1;
      stallreq_id_i = 1'b0;
      stallreq_ex_i = 1'b0;
      mc_start_i    = 1'b0;
      mc_cycles_i   = 6'd0;
      flush_i       = 1'b0;
      @(posedge clk);
      #1;

      // Reset with requests active: all outputs forced low
      for (int i = 0; i < 3; i++) begin
         apply("reset", 1'b1, 1'b1, 1'b0, 1'b1, 6'd4, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0);
      end
      idle("post_reset", 2);

      // Load-use for a single cycle
      apply("load_use", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, S_ID, 1'b0, 1'b0, 1'b0);
      idle("load_use_rel", 1);

      // Multi-cycle N=4
      apply("mc4_start", 1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0, S_EX, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         apply("mc4_run", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_EX, 1'b1, 1'b0, 1'b0);
      end
      apply("mc4_done", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_NONE, 1'b0, 1'b1, 1'b0);
      idle("mc4_idle", 1);

      // N=0 behaves as N=1
      apply("mc0_start", 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, S_EX, 1'b0, 1'b0, 1'b0);
      apply("mc0_done", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_NONE, 1'b0, 1'b1, 1'b0);
      idle("mc0_idle", 1);

      // N=1, then a back-to-back N=2 issued in the DONE cycle
      apply("mc1_start", 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, S_EX, 1'b0, 1'b0, 1'b0);
      apply("b2b_start", 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, S_EX, 1'b0, 1'b1, 1'b0);
      apply("b2b_run", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_EX, 1'b1, 1'b0, 1'b0);
      apply("b2b_done", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_NONE, 1'b0, 1'b1, 1'b0);
      idle("b2b_idle", 1);

      // Flush in the middle of an N=10 op: no done pulse afterwards
      apply("fl_start", 1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 1'b0, S_EX, 1'b0, 1'b0, 1'b0);
      apply("fl_run", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_EX, 1'b1, 1'b0, 1'b0);
      apply("fl_run", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_EX, 1'b1, 1'b0, 1'b0);
      apply("fl_cycle", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, S_NONE, 1'b1, 1'b0, 1'b0);
      idle("fl_after", 12);

      // Start in the flush cycle is dropped
      apply("fl_start_drop", 1'b0, 1'b1, 1'b1, 1'b1, 6'd3, 1'b1, S_NONE, 1'b0, 1'b0, 1'b0);
      idle("fl_drop_after", 2);

      // Simultaneous ID and EX: EX wins; then ID alone
      apply("id_ex", 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, S_EX, 1'b0, 1'b0, 1'b0);
      apply("id_after_ex", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, S_ID, 1'b0, 1'b0, 1'b0);
      idle("id_ex_idle", 1);

      // Start during RUN is ignored (N=3)
      apply("ign_start", 1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, S_EX, 1'b0, 1'b0, 1'b0);
      apply("ign_run1", 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, S_EX, 1'b1, 1'b0, 1'b0);
      apply("ign_run2", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_EX, 1'b1, 1'b0, 1'b0);
      apply("ign_done", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_NONE, 1'b0, 1'b1, 1'b0);
      idle("ign_idle", 1);

      // Reset in the middle of an op
      apply("rst_mid_start", 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, S_EX, 1'b0, 1'b0, 1'b0);
      apply("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0);
      idle("rst_mid_after", 2);

`ifndef STALL_WATCHDOG_EN
      // Maximum length 63: 63 stall cycles, then done
      apply("max_start", 1'b0, 1'b0, 1'b0, 1'b1, 6'd63, 1'b0, S_EX, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 62; i++) begin
         apply("max_run", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_EX, 1'b1, 1'b0, 1'b0);
      end
      apply("max_done", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_NONE, 1'b0, 1'b1, 1'b0);
      idle("max_idle", 1);

      // Long EX hold without a watchdog: stall stays, wdog stays low
      for (int i = 0; i < 70; i++) begin
         apply("long_ex", 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, S_EX, 1'b0, 1'b0, 1'b0);
      end
      idle("long_ex_rel", 1);
`else
      // Watchdog, limit 8: trips after the 8th consecutive stall cycle
      for (int i = 0; i < 8; i++) begin
         apply("wd_hold", 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, S_EX, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         apply("wd_tripped", 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b1);
      end
      apply("wd_start_blk", 1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0, S_NONE, 1'b0, 1'b0, 1'b1);
      apply("wd_id_blk", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b1);
      apply("wd_flush_keep", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, S_NONE, 1'b0, 1'b0, 1'b1);
      apply("wd_rst", 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0);
      apply("wd_cleared", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, S_ID, 1'b0, 1'b0, 1'b0);
      idle("wd_idle", 1);
`endif

      // Drain the scoreboard with a bounded wait
      for (int i = 0; (i < 10) && (sb_q.size() > 0); i++) begin
         @(negedge clk);
         #1;
      end
      if (sb_q.size() > 0) begin
         n_err = n_err + 1;
         $display("FAIL drain: %0d expectations left in queue, expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
